fifo_wr_packer: RTL and testbench

//  Write-side feeder for the dual-clock FIFO, in the wr_clk domain.

---
 rtl/fifo_wr_packer_if.sv | 33 +++
 rtl/fifo_wr_packer.sv | 103 ++++++++++
 tb/tb_fifo_wr_packer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_packer_if.sv
// fifo_wr_packer_if
//   Bundles the narrow input stream and the FIFO write port of the packer.
//   Ports (signals):
//     in_data  [IW]  input beat            in_valid  beat valid
//     in_last        last beat of packet   in_ready  beat accepted
//     fifo_din [DW]  word to FIFO din      fifo_we   FIFO write enable
//     fifo_full      FIFO full flag        fifo_full_n  FIFO almost-full flag
//   Modports:
//     slave  : the packer's view (consumes the stream, drives the FIFO port)
//     master : the environment's view (produces the stream, models the FIFO)
interface fifo_wr_packer_if #(
  parameter int IW = 8,
  parameter int DW = 32
);
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [DW-1:0] fifo_din;
  logic          fifo_we;
  logic          fifo_full;
  logic          fifo_full_n;

  modport slave (
    input  in_data, in_valid, in_last, fifo_full, fifo_full_n,
    output in_ready, fifo_din, fifo_we
  );

  modport master (
    output in_data, in_valid, in_last, fifo_full, fifo_full_n,
    input  in_ready, fifo_din, fifo_we
  );
endinterface

// File: rtl/fifo_wr_packer.sv
// fifo_wr_packer
//   Write-side feeder for the dual-clock FIFO (wr_clk domain). Packs RATIO
//   narrow beats into one FIFO word, lane 0 in the LSBs. in_last closes a
//   partial word early; unwritten upper lanes are filled with PAD.
//   Ports:
//     wr_clk    write-domain clock
//     rst       synchronous reset, active-low
//     clr       synchronous clear, active-high (same pulse clears the FIFO)
//     bus       stream + FIFO write port (fifo_wr_packer_if.slave)
//     words_wr  16-bit count of words written, wraps
//     lane      current fill lane (debug view of the packing state)
//
//   Handshake: a beat transfers on a wr_clk edge where in_valid & in_ready.
//   in_ready does not depend on in_valid. A FIFO word transfers on the edge
//   where fifo_we=1; fifo_we never rises while fifo_full=1.
module fifo_wr_packer #(
  parameter int          IW       = 8,
  parameter int          RATIO    = 4,
  parameter int          DW       = IW * RATIO,
  parameter int          LW       = 2,
  parameter logic [IW-1:0] PAD    = '0,
  parameter bit          AF_THROT = 1'b1
) (
  input  logic                     wr_clk,
  input  logic                     rst,
  input  logic                     clr,
  fifo_wr_packer_if.slave          bus,
  output logic [15:0]              words_wr,
  output logic [LW-1:0]            lane
);

  logic [LW-1:0] lane_q;
  logic [DW-1:0] asm_q;
  logic [DW-1:0] out_word_q;
  logic          out_vld_q;
  logic [15:0]   words_q;

  logic          run;
  logic          accept;
  logic          complete;
  logic          drain;
  logic [DW-1:0] new_word;

  assign run = rst & ~clr;

  // The holding register can take a new word if it is empty or is being
  // drained on this same edge; almost-full throttles the input only.
  assign bus.in_ready = run & (~out_vld_q | ~bus.fifo_full) &
                        ~(AF_THROT & bus.fifo_full_n);
  assign bus.fifo_we  = run & out_vld_q & ~bus.fifo_full;
  assign bus.fifo_din = out_word_q;

  assign accept   = bus.in_valid & bus.in_ready;
  assign complete = accept & ((lane_q == LW'(RATIO - 1)) | bus.in_last);
  assign drain    = bus.fifo_we;

  assign words_wr = words_q;
  assign lane     = lane_q;

  // Word that a completing beat produces: lanes below the current one come
  // from the assembly register, the current lane is the incoming beat and
  // anything above it is padding.
  always_comb begin
    new_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (i < int'(lane_q))
        new_word[i*IW +: IW] = asm_q[i*IW +: IW];
      else if (i == int'(lane_q))
        new_word[i*IW +: IW] = bus.in_data;
      else
        new_word[i*IW +: IW] = PAD;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (!rst || clr) begin
      lane_q     <= '0;
      asm_q      <= '0;
      out_word_q <= '0;
      out_vld_q  <= 1'b0;
      words_q    <= '0;
    end else begin
      if (complete) begin
        out_word_q <= new_word;
        lane_q     <= '0;
        asm_q      <= '0;
      end else if (accept) begin
        asm_q[int'(lane_q)*IW +: IW] <= bus.in_data;
        lane_q                       <= lane_q + LW'(1);
      end

      // A new word loading on a drain edge keeps the register occupied.
      if (complete)
        out_vld_q <= 1'b1;
      else if (drain)
        out_vld_q <= 1'b0;

      if (drain)
        words_q <= words_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_packer.sv
module tb_fifo_wr_packer;

  localparam int IW = 8;
  localparam int RATIO = 4;
  localparam int DW = 32;
  localparam int LW = 2;

  logic          wr_clk;
  logic          rst;
  logic          clr;
  logic [15:0]   words_wr;
  logic [LW-1:0] lane;

  int checks;
  int errors;
  int wr_seen;
  logic [DW-1:0] exp_q[$];

  fifo_wr_packer_if #(.IW(IW), .DW(DW)) bus ();

  fifo_wr_packer #(
    .IW(IW), .RATIO(RATIO), .DW(DW), .LW(LW), .PAD(8'h00), .AF_THROT(1'b1)
  ) dut (
    .wr_clk   (wr_clk),
    .rst      (rst),
    .clr      (clr),
    .bus      (bus),
    .words_wr (words_wr),
    .lane     (lane)
  );

  // clock / reset block
  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  // scoreboard: every FIFO write must match the next expected word
  always @(negedge wr_clk) begin
    if (bus.fifo_we === 1'b1) begin
      wr_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_write: unexpected write din=%h", bus.fifo_din);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.fifo_din !== e) begin
          errors++;
          $display("FAIL sb_word: got %h expected %h", bus.fifo_din, e);
        end
      end
    end
  end

  // driver: present one beat (called at posedge+1), return at posedge+1
  // after it was accepted
  task automatic send_beat(input logic [IW-1:0] d, input logic l, output int waited);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    waited = 0;
    @(negedge wr_clk);
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge wr_clk);
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: in_ready=%b expected 1 within 50 cycles", bus.in_ready);
    end
    @(posedge wr_clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge wr_clk);
    @(posedge wr_clk);
    #1;
    @(negedge wr_clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.fifo_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", bus.fifo_we); end
    checks++; if (words_wr !== 16'h0) begin errors++; $display("FAIL rst_words: got %h expected 0", words_wr); end
    checks++; if (lane !== 2'd0) begin errors++; $display("FAIL rst_lane: got %0d expected 0", lane); end
    checks++; if (bus.fifo_din !== 32'h0) begin errors++; $display("FAIL rst_din: got %h expected 0", bus.fifo_din); end
    next_cycle();
    rst = 1'b1;
    wr_seen = 0;
    @(negedge wr_clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", bus.in_ready); end
    next_cycle();
  endtask

  task automatic test_full_word();
    int w;
    exp_q.push_back(32'h44332211);
    send_beat(8'h11, 1'b0, w);
    send_beat(8'h22, 1'b0, w);
    send_beat(8'h33, 1'b0, w);
    send_beat(8'h44, 1'b0, w);
    @(negedge wr_clk);
    checks++; if (bus.fifo_we !== 1'b1) begin errors++; $display("FAIL full_we: got %b expected 1", bus.fifo_we); end
    checks++; if (bus.fifo_din !== 32'h44332211) begin errors++; $display("FAIL full_din: got %h expected 44332211", bus.fifo_din); end
    next_cycle();
    @(negedge wr_clk);
    checks++; if (bus.fifo_we !== 1'b0) begin errors++; $display("FAIL full_we_once: got %b expected 0", bus.fifo_we); end
    checks++; if (words_wr !== 16'd1) begin errors++; $display("FAIL full_words: got %0d expected 1", words_wr); end
    next_cycle();
  endtask

  task automatic test_last();
    int w;
    exp_q.push_back(32'h0000BBAA);
    send_beat(8'hAA, 1'b0, w);
    send_beat(8'hBB, 1'b1, w);
    @(negedge wr_clk);
    checks++; if (bus.fifo_we !== 1'b1) begin errors++; $display("FAIL last_we: got %b expected 1", bus.fifo_we); end
    checks++; if (bus.fifo_din !== 32'h0000BBAA) begin errors++; $display("FAIL last_din: got %h expected 0000bbaa", bus.fifo_din); end
    checks++; if (lane !== 2'd0) begin errors++; $display("FAIL last_lane: got %0d expected 0", lane); end
    next_cycle();
    @(negedge wr_clk);
    checks++; if (words_wr !== 16'd2) begin errors++; $display("FAIL last_words: got %0d expected 2", words_wr); end
    next_cycle();
  endtask

  task automatic test_full_stall();
    int w;
    int total;
    exp_q.push_back(32'hC4C3C2C1);
    send_beat(8'hC1, 1'b0, w);
    send_beat(8'hC2, 1'b0, w);
    send_beat(8'hC3, 1'b0, w);
    send_beat(8'hC4, 1'b0, w);
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge wr_clk);
      checks++; if (bus.fifo_we !== 1'b0) begin errors++; $display("FAIL stall_we[%0d]: got %b expected 0", i, bus.fifo_we); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, bus.in_ready); end
      checks++; if (bus.fifo_din !== 32'hC4C3C2C1) begin errors++; $display("FAIL stall_din[%0d]: got %h expected c4c3c2c1", i, bus.fifo_din); end
      next_cycle();
    end
    bus.fifo_full = 1'b0;
    @(negedge wr_clk);
    checks++; if (bus.fifo_we !== 1'b1) begin errors++; $display("FAIL unstall_we: got %b expected 1", bus.fifo_we); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL unstall_ready: got %b expected 1", bus.in_ready); end
    next_cycle();
    exp_q.push_back(32'hD4D3D2D1);
    exp_q.push_back(32'hD8D7D6D5);
    total = 0;
    for (int i = 1; i <= 8; i++) begin
      send_beat(8'hD0 + 8'(i), 1'b0, w);
      total += w;
    end
    checks++; if (total !== 0) begin errors++; $display("FAIL stream_rate: stall cycles %0d expected 0", total); end
    next_cycle();
    @(negedge wr_clk);
    checks++; if (words_wr !== 16'd5) begin errors++; $display("FAIL stream_words: got %0d expected 5", words_wr); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL stream_pending: %0d words unwritten expected 0", exp_q.size()); end
    next_cycle();
  endtask

  task automatic test_rst_midword();
    int w;
    send_beat(8'h55, 1'b0, w);
    send_beat(8'h66, 1'b0, w);
    rst = 1'b0;
    @(negedge wr_clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.fifo_we !== 1'b0) begin errors++; $display("FAIL mid_rst_we: got %b expected 0", bus.fifo_we); end
    next_cycle();
    rst = 1'b1;
    wr_seen = 0;
    @(negedge wr_clk);
    checks++; if (lane !== 2'd0) begin errors++; $display("FAIL mid_rst_lane: got %0d expected 0", lane); end
    checks++; if (words_wr !== 16'd0) begin errors++; $display("FAIL mid_rst_words: got %0d expected 0", words_wr); end
    next_cycle();
    send_beat(8'h77, 1'b0, w);
    clr = 1'b1;
    @(negedge wr_clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %b expected 0", bus.in_ready); end
    next_cycle();
    clr = 1'b0;
    @(negedge wr_clk);
    checks++; if (lane !== 2'd0) begin errors++; $display("FAIL clr_lane: got %0d expected 0", lane); end
    next_cycle();
    exp_q.push_back(32'h04030201);
    send_beat(8'h01, 1'b0, w);
    send_beat(8'h02, 1'b0, w);
    send_beat(8'h03, 1'b0, w);
    send_beat(8'h04, 1'b0, w);
    next_cycle();
    @(negedge wr_clk);
    checks++; if (words_wr !== 16'd1) begin errors++; $display("FAIL mid_words: got %0d expected 1", words_wr); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL mid_pending: %0d words unwritten expected 0", exp_q.size()); end
    next_cycle();
  endtask

  task automatic test_almost_full();
    int w;
    bus.fifo_full = 1'b1;
    exp_q.push_back(32'hE4E3E2E1);
    send_beat(8'hE1, 1'b0, w);
    send_beat(8'hE2, 1'b0, w);
    send_beat(8'hE3, 1'b0, w);
    send_beat(8'hE4, 1'b0, w);
    bus.fifo_full_n = 1'b1;
    bus.fifo_full   = 1'b0;
    @(negedge wr_clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL af_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.fifo_we !== 1'b1) begin errors++; $display("FAIL af_we: got %b expected 1", bus.fifo_we); end
    checks++; if (bus.fifo_din !== 32'hE4E3E2E1) begin errors++; $display("FAIL af_din: got %h expected e4e3e2e1", bus.fifo_din); end
    next_cycle();
    @(negedge wr_clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL af_ready_hold: got %b expected 0", bus.in_ready); end
    checks++; if (bus.fifo_we !== 1'b0) begin errors++; $display("FAIL af_we_once: got %b expected 0", bus.fifo_we); end
    checks++; if (words_wr !== 16'd2) begin errors++; $display("FAIL af_words: got %0d expected 2", words_wr); end
    next_cycle();
    bus.fifo_full_n = 1'b0;
    @(negedge wr_clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL af_release: got %b expected 1", bus.in_ready); end
    next_cycle();
  endtask

  task automatic test_wrap();
    int w;
    int n;
    logic [IW-1:0] d;
    n = 65535 - wr_seen;
    for (int i = 0; i < n; i++) begin
      d = 8'(i);
      exp_q.push_back({24'h0, d});
      send_beat(d, 1'b1, w);
    end
    next_cycle();
    @(negedge wr_clk);
    checks++; if (words_wr !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre: got %h expected ffff", words_wr); end
    next_cycle();
    exp_q.push_back(32'h0000005A);
    send_beat(8'h5A, 1'b1, w);
    next_cycle();
    @(negedge wr_clk);
    checks++; if (words_wr !== 16'h0000) begin errors++; $display("FAIL wrap_post: got %h expected 0000", words_wr); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL wrap_pending: %0d words unwritten expected 0", exp_q.size()); end
    next_cycle();
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    wr_seen         = 0;
    rst             = 1'b0;
    clr             = 1'b0;
    bus.in_data     = '0;
    bus.in_valid    = 1'b0;
    bus.in_last     = 1'b0;
    bus.fifo_full   = 1'b0;
    bus.fifo_full_n = 1'b0;
    #1;
    test_reset();
    test_full_word();
    test_last();
    test_full_stall();
    test_rst_midword();
    test_almost_full();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
